// File: rtl/vga_scanout.sv
// VGA raster timing plus scanout of a valid/ready pixel stream.
// The SOF-flagged stream pixel always lands on (0,0); any misalignment forces a resync.
module vga_scanout #(
  parameter int X_WIDTH       = 640,
  parameter int X_FRONT_PORCH = 16,
  parameter int X_SYNC        = 96,
  parameter int X_BACK_PORCH  = 48,
  parameter int Y_WIDTH       = 480,
  parameter int Y_FRONT_PORCH = 10,
  parameter int Y_SYNC        = 2,
  parameter int Y_BACK_PORCH  = 33,
  parameter int COLOR_DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pix_ce,
  input  logic                     pix_valid,
  input  logic                     pix_sof,
  input  logic [3*COLOR_DEPTH-1:0] pix_data,
  output logic                     pix_ready,
  output logic [COLOR_DEPTH-1:0]   VGA_R,
  output logic [COLOR_DEPTH-1:0]   VGA_G,
  output logic [COLOR_DEPTH-1:0]   VGA_B,
  output logic                     VGA_HS,
  output logic                     VGA_VS,
  output logic                     frame_start,
  output logic                     underflow,
  output logic                     locked
);

  localparam int H_TOT = X_WIDTH + X_FRONT_PORCH + X_SYNC + X_BACK_PORCH;
  localparam int V_TOT = Y_WIDTH + Y_FRONT_PORCH + Y_SYNC + Y_BACK_PORCH;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  typedef enum logic {SYNCING, RUNNING} state_t;

  state_t        state_reg;
  logic [HW-1:0] h_reg;
  logic [VW-1:0] v_reg;
  logic          at_origin;
  logic          active;
  logic          hs_next;
  logic          vs_next;
  logic          emit;

  always_comb begin
    at_origin = (h_reg == '0) && (v_reg == '0);
    active    = (h_reg < HW'(X_WIDTH)) && (v_reg < VW'(Y_WIDTH));
    hs_next   = !((h_reg >= HW'(X_WIDTH + X_FRONT_PORCH)) &&
                  (h_reg <  HW'(X_WIDTH + X_FRONT_PORCH + X_SYNC)));
    vs_next   = !((v_reg >= VW'(Y_WIDTH + Y_FRONT_PORCH)) &&
                  (v_reg <  VW'(Y_WIDTH + Y_FRONT_PORCH + Y_SYNC)));

    // While syncing, non-SOF pixels drain at clk rate; the SOF waits for (0,0).
    if (reset)
      pix_ready = 1'b0;
    else if (state_reg == SYNCING)
      pix_ready = pix_valid && (!pix_sof || (pix_ce && at_origin));
    else
      pix_ready = pix_ce && active && pix_valid && (pix_sof == at_origin);

    emit = pix_ce && pix_ready && ((state_reg == RUNNING) || pix_sof);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= SYNCING;
      h_reg       <= '0;
      v_reg       <= '0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else if (pix_ce) begin
      if (h_reg == HW'(H_TOT - 1)) begin
        h_reg <= '0;
        v_reg <= (v_reg == VW'(V_TOT - 1)) ? '0 : v_reg + 1'b1;
      end else begin
        h_reg <= h_reg + 1'b1;
      end

      VGA_HS      <= hs_next;
      VGA_VS      <= vs_next;
      {VGA_R, VGA_G, VGA_B} <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;

      if (emit) begin
        {VGA_R, VGA_G, VGA_B} <= pix_data;
        frame_start <= at_origin;
        state_reg   <= RUNNING;
      end else if ((state_reg == RUNNING) && active) begin
        // No data: blank and move on. Wrong SOF placement: drop lock.
        if (!pix_valid)
          underflow <= 1'b1;
        else
          state_reg <= SYNCING;
      end
    end else begin
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end
  end

  assign locked = (state_reg == RUNNING);

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Transmit side of the VGA display path: generates 640x480-class raster timing and drives VGA_R/G/B, VGA_HS and VGA_VS from a valid/ready pixel stream.
- Sits between the ray-tracing pixel producer and the board VGA pins.
- Guarantees pixel (0,0) of every frame is the stream pixel flagged start-of-frame.
- Reports underflow and frame-lock status.

Parameters:
- X_WIDTH, 640, active pixels per line
- X_FRONT_PORCH, 16, pixels
- X_SYNC, 96, hsync pulse width in pixels
- X_BACK_PORCH, 48, pixels
- Y_WIDTH, 480, active lines per frame
- Y_FRONT_PORCH, 10, lines
- Y_SYNC, 2, vsync pulse width in lines
- Y_BACK_PORCH, 33, lines
- COLOR_DEPTH, 4, bits per colour channel

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- pix_ce  in  1  pixel-clock enable; timing advances only when high
- pix_valid  in  1  stream pixel available
- pix_sof  in  1  head pixel is frame pixel (0,0)
- pix_data  in  3*COLOR_DEPTH  {R,G,B}, R in MSBs
- pix_ready  out  1  head pixel consumed this cycle (combinational)
- VGA_R  out  COLOR_DEPTH  red
- VGA_G  out  COLOR_DEPTH  green
- VGA_B  out  COLOR_DEPTH  blue
- VGA_HS  out  1  hsync, active low
- VGA_VS  out  1  vsync, active low
- frame_start  out  1  one-cycle pulse when (0,0) is emitted
- underflow  out  1  one-cycle pulse when an active pixel had no valid data
- locked  out  1  high in RUNNING state

Behaviour:
- Interface fixed: one clock (clk); reset is asynchronous and active-high.
- Reset values: h=0, v=0, state SYNCING, VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, frame_start=0, underflow=0, locked=0.
- Counters:
  - h counts 0..H_TOT-1, H_TOT = X_WIDTH+X_FRONT_PORCH+X_SYNC+X_BACK_PORCH.
  - v counts 0..V_TOT-1, defined the same way.
  - Both advance only on pix_ce. h wraps to 0 and increments v; v wraps to 0 after V_TOT-1.
- Region order per line/frame: active, front porch, sync, back porch.
- active = (h < X_WIDTH) && (v < Y_WIDTH).
- Sync decode:
  - HS low iff X_WIDTH+X_FRONT_PORCH <= h < X_WIDTH+X_FRONT_PORCH+X_SYNC.
  - VS low iff Y_WIDTH+Y_FRONT_PORCH <= v < Y_WIDTH+Y_FRONT_PORCH+Y_SYNC.
- Latency: all VGA outputs, frame_start and underflow are registered and update only on pix_ce edges. They reflect the (h,v) value sampled on that edge, one clk after the edge.
- Outside active, RGB = 0. Non-ce cycles hold every output; frame_start and underflow clear to 0.
- State machine:
  - SYNCING:
    - pix_ready = pix_valid && !pix_sof: non-SOF pixels are discarded at clk rate, independent of pix_ce.
    - A SOF pixel is held at the head (ready low).
    - When pix_ce && h==0 && v==0 && pix_valid && pix_sof: consume it, emit it, pulse frame_start, go RUNNING.
    - RGB = 0 throughout SYNCING; underflow is never pulsed.
  - RUNNING, on pix_ce && active:
    - At (0,0) with valid SOF: consume, emit, pulse frame_start.
    - At (0,0) with valid non-SOF: ready low, RGB 0, go SYNCING (misaligned).
    - At non-(0,0) with valid SOF: ready low, RGB 0, go SYNCING; SOF retained.
    - Valid non-SOF at non-(0,0): consume and emit.
    - pix_valid low: RGB 0, pulse underflow, stay RUNNING. The next pixel goes to the next position (no stall).
  - RUNNING, outside active or on non-ce cycles: pix_ready = 0.
- pix_ready never depends on pix_ready; it is combinational from pix_valid/pix_sof/state/counters/pix_ce only.
- Reset mid-frame: immediate return to reset values. Any pixel in flight is not consumed. Resync occurs at the next (0,0) with SOF.

Test Plan:
(Small config unless stated: X 8/2/2/2, Y 4/1/1/1, pix_ce every cycle.)
- Reset held 10 cycles -> HS=VS=1, RGB=0, locked=0, pix_ready=0 with no valid input.
- Stream 3 frames of pixels with data = v*8+h, SOF on the first of each -> locked rises at the first frame_start. HS low for exactly 2 ce per 14-ce line. VS low for exactly 1 line (14 ce) per 7-line frame. Captured active pixels equal 0..31 in order. frame_start pulses every 98 ce.
- Drop pix_valid for pixel (3,1) in frame 2 -> single underflow pulse, RGB 0 at that position, pixel 11 appears at (4,1), locked stays 1.
- Inject SOF at pixel (5,2) -> locked falls, RGB 0 for the rest of the frame, lock regained at the next (0,0) with that SOF.
- Present 5 garbage pixels before the first SOF while SYNCING -> all 5 consumed and discarded, first emitted pixel is the SOF data at (0,0).
- pix_ce every 2nd clk with default 640x480 params; assert reset at line 100 -> HS period 1600 clk, low for 192 clk. After reset, outputs return to reset values within 1 clk; relock occurs on the next frame.
